// File: rtl/ra_shadow_stack.sv
// Return-address shadow stack beside the IF/ID stage.
// Decodes calls and returns from the IF/ID instruction, pushes return addresses
// and checks each return target against the stacked address.
// Optional build macro: RAS_MISMATCH_HALT_EN -- a return-target mismatch parks the
// block in a HALT state that holds RAS_rdy low until Rst.
module ra_shadow_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic [31:0]             ins,
  input  logic [XLEN-1:0]         IF_ID_pres_addr,
  input  logic [XLEN-1:0]         branoff,
  input  logic                    if_adv,
  output logic                    RAS_rdy,
  output logic                    ras_mismatch,
  output logic                    ras_mm_sticky,
  output logic                    ras_overflow,
  output logic                    ras_underflow,
  output logic [$clog2(DEPTH):0]  ras_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef RAS_MISMATCH_HALT_EN
  localparam logic [1:0] S_HALT = 2'd3;
`endif

  logic [1:0]      state;
  logic [1:0]      state_nxt;

  logic [6:0]      opc;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic            is_jal;
  logic            is_jalr;
  logic            link_rd;
  logic            link_rs1;
  logic            dec_push;
  logic            dec_pop;
  logic            dec_event;
  logic            unused_ins;

  logic            op_push;
  logic            op_pop;
  logic [XLEN-1:0] op_val;
  logic [XLEN-1:0] op_tgt;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   top_idx;
  logic [XLEN-1:0] top_val;

  logic            mm_det;
  logic            udf_set;
  logic            ovf_set;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   ptr_nxt;
  logic [CW-1:0]   cnt_nxt;

  // Call/return decode of the instruction currently in IF/ID
  assign opc        = ins[6:0];
  assign rd         = ins[11:7];
  assign rs1        = ins[19:15];
  assign unused_ins = ^{ins[31:20], ins[14:12]};
  assign is_jal     = (opc == OPC_JAL);
  assign is_jalr    = (opc == OPC_JALR);
  assign link_rd    = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1   = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign dec_push   = (is_jal || is_jalr) && link_rd;
  assign dec_pop    = is_jalr && link_rs1 && !(link_rd && (rd == rs1));
  assign dec_event  = dec_push || dec_pop;

  assign top_idx    = ptr - PW'(1);
  assign top_val    = mem[top_idx];

  // Fetch may proceed when idle with nothing to do, or once the operation is finished
  assign RAS_rdy    = ((state == S_IDLE) && !dec_event) || (state == S_DONE);
  assign ras_count  = cnt;

  // Stack update performed during the single OP cycle
  always_comb begin
    mm_det  = 1'b0;
    udf_set = 1'b0;
    ovf_set = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (state == S_OP) begin
      if (op_pop && (cnt != '0)) begin
        mm_det = (top_val != op_tgt);
        if (op_push) begin
          // Tail-call style swap: the new return address replaces the checked top
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          ptr_nxt = top_idx;
          cnt_nxt = cnt - CW'(1);
        end
      end else begin
        if (op_pop) begin
          udf_set = 1'b1;
        end
        if (op_push) begin
          wr_en   = 1'b1;
          wr_idx  = ptr;
          ptr_nxt = ptr + PW'(1);
          if (cnt == CW'(DEPTH)) begin
            ovf_set = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (dec_event) begin
          state_nxt = S_OP;
        end
      end
      S_OP: begin
`ifdef RAS_MISMATCH_HALT_EN
        state_nxt = mm_det ? S_HALT : S_DONE;
`else
        state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        if (if_adv) begin
          state_nxt = S_IDLE;
        end
      end
`ifdef RAS_MISMATCH_HALT_EN
      S_HALT: begin
        state_nxt = S_HALT;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the decoded operation when leaving IDLE
  always_ff @(posedge clk) begin
    if (Rst) begin
      op_push <= 1'b0;
      op_pop  <= 1'b0;
      op_val  <= '0;
      op_tgt  <= '0;
    end else if ((state == S_IDLE) && dec_event) begin
      op_push <= dec_push;
      op_pop  <= dec_pop;
      op_val  <= IF_ID_pres_addr + XLEN'(4);
      op_tgt  <= branoff;
    end
  end

  // Stack pointer, occupancy and status flags
  always_ff @(posedge clk) begin
    if (Rst) begin
      ptr           <= '0;
      cnt           <= '0;
      ras_mismatch  <= 1'b0;
      ras_mm_sticky <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ptr           <= ptr_nxt;
      cnt           <= cnt_nxt;
      ras_mismatch  <= mm_det;
      ras_mm_sticky <= ras_mm_sticky | mm_det;
      ras_overflow  <= ras_overflow | ovf_set;
      ras_underflow <= ras_underflow | udf_set;
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (wr_en && !Rst) begin
      mem[wr_idx] <= op_val;
    end
  end

endmodule

// File: tb/tb_ra_shadow_stack.sv
// Scoreboard bench for ra_shadow_stack: directed call/return scenarios followed by
// random instruction traffic, checked against a queue-based return-address model.
module tb_ra_shadow_stack;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            Rst;
  logic [31:0]     ins;
  logic [XLEN-1:0] IF_ID_pres_addr;
  logic [XLEN-1:0] branoff;
  logic            if_adv;
  logic            RAS_rdy;
  logic            ras_mismatch;
  logic            ras_mm_sticky;
  logic            ras_overflow;
  logic            ras_underflow;
  logic [4:0]      ras_count;

  ra_shadow_stack #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk             (clk),
    .Rst             (Rst),
    .ins             (ins),
    .IF_ID_pres_addr (IF_ID_pres_addr),
    .branoff         (branoff),
    .if_adv          (if_adv),
    .RAS_rdy         (RAS_rdy),
    .ras_mismatch    (ras_mismatch),
    .ras_mm_sticky   (ras_mm_sticky),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow),
    .ras_count       (ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic mm;
    int   cnt;
    logic sticky;
    logic ovf;
    logic udf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] stk[$];
  logic        m_sticky;
  logic        m_ovf;
  logic        m_udf;
  int          n_vec = 0;
  int          n_err = 0;
  int          txn_id = 0;

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [31:0] mk_jal(input logic [4:0] rd);
    logic [31:0] r;
    r = $urandom;
    return {r[31:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] mk_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    logic [31:0] r;
    r = $urandom;
    return {r[31:20], rs1, r[14:12], rd, 7'b1100111};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_sticky = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  // Return-address semantics: a LIFO of at most DEPTH addresses, oldest lost on overflow
  task automatic model_step(input bit push, input bit pop, input logic [31:0] val,
                            input logic [31:0] tgt, output bit mm);
    mm = 1'b0;
    if (pop && (stk.size() > 0)) begin
      mm = (stk[stk.size()-1] != tgt);
      if (push) stk[stk.size()-1] = val;
      else      void'(stk.pop_back());
    end else begin
      if (pop) m_udf = 1'b1;
      if (push) begin
        if (stk.size() == DEPTH) begin
          void'(stk.pop_front());
          m_ovf = 1'b1;
        end
        stk.push_back(val);
      end
    end
    if (mm) m_sticky = 1'b1;
  endtask

  task automatic do_reset();
    ins    = NOP;
    if_adv = 1'b0;
    Rst    = 1'b1;
    @(posedge clk);
    #1;
    Rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_rdy",  32'(RAS_rdy),       32'd1);
    check("reset_cnt",  32'(ras_count),     32'd0);
    check("reset_mm",   32'(ras_mismatch),  32'd0);
    check("reset_stk",  32'(ras_mm_sticky), 32'd0);
    check("reset_ovf",  32'(ras_overflow),  32'd0);
    check("reset_udf",  32'(ras_underflow), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IF/ID; entered and left #1 after a posedge with the DUT idle
  task automatic do_txn(input logic [31:0] i, input logic [31:0] pc,
                        input logic [31:0] tgt, input int hold);
    bit   push;
    bit   pop;
    bit   mm;
    bit   got;
    exp_t e;
    push = ((i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100111)) && is_link(i[11:7]);
    pop  = (i[6:0] == 7'b1100111) && is_link(i[19:15]) &&
           !(is_link(i[11:7]) && (i[11:7] == i[19:15]));
    ins             = i;
    IF_ID_pres_addr = pc;
    branoff         = tgt;
    if_adv          = 1'b0;
    if (!(push || pop)) begin
      @(negedge clk);
      check("rdy_no_event", 32'(RAS_rdy), 32'd1);
      if_adv = 1'b1;
      @(posedge clk);
      #1;
      if_adv = 1'b0;
    end else begin
      model_step(push, pop, pc + 32'd4, tgt, mm);
      txn_id++;
      e.id     = txn_id;
      e.mm     = mm;
      e.cnt    = stk.size();
      e.sticky = m_sticky;
      e.ovf    = m_ovf;
      e.udf    = m_udf;
      exp_q.push_back(e);
      @(negedge clk);
      check("rdy_event_stall", 32'(RAS_rdy), 32'd0);
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (RAS_rdy) begin
          got = 1'b1;
          break;
        end
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL rdy_timeout: txn %0d RAS_rdy stayed 0 expected 1", txn_id);
      end
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        check("done_hold_rdy", 32'(RAS_rdy), 32'd1);
      end
      if_adv = 1'b1;
      @(posedge clk);
      #1;
      if_adv = 1'b0;
    end
  endtask

  // Monitor: the first ready cycle after a stall is the DONE cycle carrying the result
  initial begin : monitor
    logic rdy_q;
    exp_t e;
    rdy_q = 1'b1;
    forever begin
      @(negedge clk);
      if (Rst) begin
        rdy_q = 1'b1;
      end else begin
        if (RAS_rdy && !rdy_q) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: DONE seen with empty scoreboard at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            n_vec++;
            if ((ras_mismatch !== e.mm) || (32'(ras_count) !== 32'(e.cnt)) ||
                (ras_mm_sticky !== e.sticky) || (ras_overflow !== e.ovf) ||
                (ras_underflow !== e.udf)) begin
              n_err++;
              $display("FAIL sb_txn%0d: got mm=%0b cnt=%0d stk=%0b ovf=%0b udf=%0b expected mm=%0b cnt=%0d stk=%0b ovf=%0b udf=%0b",
                       e.id, ras_mismatch, ras_count, ras_mm_sticky, ras_overflow, ras_underflow,
                       e.mm, e.cnt, e.sticky, e.ovf, e.udf);
            end
          end
        end else begin
          n_vec++;
          if (ras_mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL mm_pulse: got %0b expected 0 outside first DONE cycle at %0t",
                     ras_mismatch, $time);
          end
        end
        rdy_q = RAS_rdy;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [4:0]  pool [4];
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] r;
    logic [31:0] pc;
    logic [31:0] tgt;
    int          sel;

    Rst             = 1'b1;
    ins             = NOP;
    IF_ID_pres_addr = '0;
    branoff         = '0;
    if_adv          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Call then matching return
    do_txn(mk_jal(5'd1), 32'h100, 32'h0, 3);
    do_txn(mk_jalr(5'd0, 5'd1), 32'h200, 32'h104, 1);
    // Call then wrong return target
    do_txn(mk_jal(5'd1), 32'h100, 32'h0, 0);
    do_txn(mk_jalr(5'd0, 5'd1), 32'h300, 32'h200, 2);
    // Overflow by one, unwind the survivors, then underflow
    for (int k = 0; k <= DEPTH; k++) do_txn(mk_jal(5'd1), 32'(k * 16), 32'h0, 0);
    for (int k = DEPTH; k >= 1; k--) do_txn(mk_jalr(5'd0, 5'd1), 32'h500, 32'(k * 16 + 4), 0);
    do_txn(mk_jalr(5'd0, 5'd5), 32'h600, 32'h14, 0);
    // Swap: return via x5 while linking into x1
    do_txn(mk_jal(5'd5), 32'h3c, 32'h0, 0);
    do_txn(mk_jalr(5'd1, 5'd5), 32'h80, 32'h40, 1);
    do_txn(mk_jalr(5'd0, 5'd1), 32'h90, 32'h84, 0);
    // Sticky flags clear only on reset
    do_reset();

    pool[0] = 5'd0;
    pool[1] = 5'd1;
    pool[2] = 5'd5;
    for (int n = 0; n < 400; n++) begin
      pool[3] = 5'($urandom_range(0, 31));
      rd  = pool[$urandom_range(0, 3)];
      rs1 = pool[$urandom_range(0, 3)];
      pc  = $urandom & 32'hFFFF_FFFC;
      if ((n % 7) == 6) pc = 32'hFFFF_FFFC;
      if ((stk.size() > 0) && ($urandom_range(0, 3) != 0)) tgt = stk[stk.size()-1];
      else tgt = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        r = $urandom;
        case ($urandom_range(0, 2))
          0:       r[6:0] = 7'b0010011;
          1:       r[6:0] = 7'b0110011;
          default: r[6:0] = 7'b0000011;
        endcase
        do_txn(r, pc, tgt, 0);
      end else if (sel < 6) begin
        do_txn(mk_jal(rd), pc, tgt, $urandom_range(0, 3));
      end else begin
        do_txn(mk_jalr(rd, rs1), pc, tgt, $urandom_range(0, 3));
      end
      if (n == 200) do_reset();
    end

    ins = NOP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
